// File: rtl/uart_tx_if.sv
// Host-side bundle of the UART transmitter: byte enqueue strobe, FIFO status and serial line.
interface uart_tx_if #(
    parameter int unsigned FIFO_AW = 4
);
    logic [7:0]       tx_byte;
    logic             tx_wr;
    logic             tx_full;
    logic             tx_busy;
    logic [FIFO_AW:0] fifo_count;
    logic             tx;

    // Producer of bytes (CPU/trace logic) and observer of status
    modport master (
        output tx_byte,
        output tx_wr,
        input  tx_full,
        input  tx_busy,
        input  fifo_count,
        input  tx
    );

    // The transmitter itself
    modport slave (
        input  tx_byte,
        input  tx_wr,
        output tx_full,
        output tx_busy,
        output fifo_count,
        output tx
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO. Frames are sent LSB-first, back-to-back frames
// follow each other with no idle gap. All outputs are registered.
module uart_tx #(
    parameter int unsigned DIVISOR = 52,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic     clk,
    input  logic     RESET,
    uart_tx_if.slave bus
);

    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned BAUD_W = $clog2(DIVISOR);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] count_q, count_d;
    logic             full_q, full_d;
    logic             busy_q, busy_d;
    logic             tx_q, tx_d;

    logic [7:0]       mem [DEPTH];

    logic             tick;
    logic             fifo_empty;
    logic             wr_en;
    logic             pop;
    logic [7:0]       head_byte;

    assign tick       = (baud_q == BAUD_W'(DIVISOR - 1));
    assign fifo_empty = (count_q == '0);
    // Full is judged on the registered count only; a same-cycle pop does not free a slot
    assign wr_en      = bus.tx_wr && !full_q;
    assign head_byte  = mem[rd_ptr_q[FIFO_AW-1:0]];

    // FIFO storage: no reset needed, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= bus.tx_byte;
        end
    end

    // Frame sequencer: bit timer, bit counter, shifter and pop decision
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head_byte;
                    state_d = StStart;
                end
            end
            StStart: begin
                baud_d = tick ? '0 : baud_q + 1'b1;
                if (tick) begin
                    bit_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                baud_d = tick ? '0 : baud_q + 1'b1;
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                baud_d = tick ? '0 : baud_q + 1'b1;
                if (tick) begin
                    // Chain straight into the next start bit when more data is waiting
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head_byte;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
            end
        endcase
    end

    // FIFO pointers, occupancy and status flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d = (count_d == (FIFO_AW + 1)'(DEPTH));
        // Busy follows the registered state so it trails an accepted write by one edge
        busy_d = !fifo_empty || (state_q != StIdle);
    end

    // Line level is decoded from the registered state, one edge behind the sequencer
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State register; reset abandons any frame and returns the line high immediately
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            busy_q   <= busy_d;
            tx_q     <= tx_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.tx_full    = full_q;
    assign bus.tx_busy    = busy_q;
    assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a serial-line receiver model decodes frames from tx,
// tests compare decoded bytes and frame timing against expectations derived from the
// 8N1 framing rules and the documented write-to-line latency.
module tb_uart_tx;
    localparam int unsigned DIVISOR = 52;
    localparam int unsigned FIFO_AW = 4;
    localparam int          FRAME   = 10 * DIVISOR;

    logic clk   = 1'b0;
    logic RESET = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] rx_q[$];
    int         fall_q[$];
    logic [7:0] exp_q[$];
    int         f_a;

    uart_tx_if #(.FIFO_AW(FIFO_AW)) bus ();

    uart_tx #(.DIVISOR(DIVISOR), .FIFO_AW(FIFO_AW)) dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Edge index: at a negedge, cyc equals the index of the posedge just passed
    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: on a falling edge, watch ten bit windows of DIVISOR cycles each,
    // require each window to be constant, sample mid-bit, abandon the frame on reset.
    initial begin : rx_model
        logic       prev;
        logic [9:0] bits;
        logic       level;
        logic       abort;
        logic       glitch;
        int         f;
        prev = 1'b1;
        bits = '0;
        level = 1'b1;
        forever begin
            @(negedge clk);
            if (RESET) begin
                prev = 1'b1;
                continue;
            end
            if (prev === 1'b1 && bus.tx === 1'b0) begin
                f      = cyc;
                abort  = 1'b0;
                glitch = 1'b0;
                for (int b = 0; b < 10 && !abort; b++) begin
                    for (int s = 0; s < DIVISOR; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (RESET) begin
                            abort = 1'b1;
                            break;
                        end
                        if (s == 0) level = bus.tx;
                        else if (bus.tx !== level) glitch = 1'b1;
                        if (s == DIVISOR / 2) bits[b] = bus.tx;
                    end
                end
                if (abort) begin
                    prev = 1'b1;
                    continue;
                end
                checks++;
                if (glitch || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_format at %0d: glitch=%0b start=%0b stop=%0b, need 0/0/1",
                             f, glitch, bits[0], bits[9]);
                end
                rx_q.push_back(bits[8:1]);
                fall_q.push_back(f);
            end
            prev = bus.tx;
        end
    end

    // Present one byte for the next posedge; returns at the negedge after it (cyc == n)
    task automatic write_byte(input logic [7:0] b, output int n);
        bus.tx_byte = b;
        bus.tx_wr   = 1'b1;
        n           = cyc + 1;
        @(negedge clk);
        bus.tx_wr   = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int waited = 0;
        while (rx_q.size() < n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.tx_wr = 1'b0;
        bus.tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1) begin
            errors++; $display("FAIL reset_tx: got %0b, need 1", bus.tx);
        end
        checks++;
        if (bus.tx_full !== 1'b0) begin
            errors++; $display("FAIL reset_full: got %0b, need 0", bus.tx_full);
        end
        checks++;
        if (bus.tx_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %0b, need 0", bus.tx_busy);
        end
        checks++;
        if (bus.fifo_count !== '0) begin
            errors++; $display("FAIL reset_count: got %0d, need 0", bus.fifo_count);
        end
        RESET = 1'b0;
        repeat (2) @(negedge clk);
        rx_q.delete();
        fall_q.delete();
    endtask

    task automatic test_single();
        int n;
        bit ok;
        logic [7:0] got;
        write_byte(8'h55, n);
        checks++;
        if (bus.fifo_count !== 5'd1) begin
            errors++; $display("FAIL single_count_after_write: got %0d, need 1", bus.fifo_count);
        end
        wait_cyc(n + 1);
        checks++;
        if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b1 || bus.fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL single_pop: tx=%0b busy=%0b count=%0d, need 1/1/0",
                     bus.tx, bus.tx_busy, bus.fifo_count);
        end
        wait_cyc(n + 2);
        checks++;
        if (bus.tx !== 1'b0) begin
            errors++; $display("FAIL single_start_latency: tx got %0b, need 0", bus.tx);
        end
        wait_cyc(n + 2 + FRAME - 1);
        checks++;
        if (bus.tx_busy !== 1'b1) begin
            errors++; $display("FAIL single_busy_in_stop: got %0b, need 1", bus.tx_busy);
        end
        wait_cyc(n + 2 + FRAME);
        checks++;
        if (bus.tx_busy !== 1'b0 || bus.tx !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_end: busy=%0b tx=%0b, need 0/1", bus.tx_busy, bus.tx);
        end
        wait_rx(1, FRAME, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_rx_timeout: got %0d bytes, need 1", rx_q.size());
        end else begin
            got = rx_q.pop_front();
            checks++;
            if (got !== 8'h55) begin
                errors++; $display("FAIL single_data: got %02h, need 55", got);
            end
            checks++;
            if (fall_q[0] !== n + 2) begin
                errors++; $display("FAIL single_fall_time: got %0d, need %0d", fall_q[0], n + 2);
            end
            void'(fall_q.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int n0;
        int peak;
        bit ok;
        logic [7:0] got;
        int f;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'hA5;
        peak = 0;
        n0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            bus.tx_byte = bytes[i];
            bus.tx_wr   = 1'b1;
            @(negedge clk);
            if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
        end
        bus.tx_wr = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
        end
        checks++;
        if (peak != 2) begin
            errors++; $display("FAIL burst_peak_count: got %0d, need 2", peak);
        end
        wait_cyc(n0 + 2 + 3 * FRAME - 1);
        checks++;
        if (bus.tx_busy !== 1'b1) begin
            errors++; $display("FAIL burst_busy_last_stop: got %0b, need 1", bus.tx_busy);
        end
        wait_cyc(n0 + 2 + 3 * FRAME);
        checks++;
        if (bus.tx_busy !== 1'b0) begin
            errors++; $display("FAIL burst_busy_end: got %0b, need 0", bus.tx_busy);
        end
        wait_rx(3, FRAME, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL burst_rx_timeout: got %0d bytes, need 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = rx_q.pop_front();
                f   = fall_q.pop_front();
                checks++;
                if (got !== bytes[i] || f != n0 + 2 + i * FRAME) begin
                    errors++;
                    $display("FAIL burst_frame%0d: data %02h at %0d, need %02h at %0d",
                             i, got, f, bytes[i], n0 + 2 + i * FRAME);
                end
            end
        end
    endtask

    task automatic test_full();
        int n;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        write_byte(a, n);
        f_a = n + 2;
        exp_q.delete();
        exp_q.push_back(a);
        wait_cyc(n + 3);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            bus.tx_byte = b;
            bus.tx_wr   = 1'b1;
            @(negedge clk);
            if (i < 16) exp_q.push_back(b);
            if (i == 14) begin
                checks++;
                if (bus.tx_full !== 1'b0 || bus.fifo_count !== 5'd15) begin
                    errors++;
                    $display("FAIL full_at_15: full=%0b count=%0d, need 0/15",
                             bus.tx_full, bus.fifo_count);
                end
            end
            if (i == 15) begin
                checks++;
                if (bus.tx_full !== 1'b1 || bus.fifo_count !== 5'd16) begin
                    errors++;
                    $display("FAIL full_at_16: full=%0b count=%0d, need 1/16",
                             bus.tx_full, bus.fifo_count);
                end
            end
        end
        bus.tx_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.tx_full !== 1'b1 || bus.fifo_count !== 5'd16) begin
            errors++;
            $display("FAIL full_drop_17th: full=%0b count=%0d, need 1/16",
                     bus.tx_full, bus.fifo_count);
        end
    endtask

    task automatic test_full_pop_race();
        int p;
        bit ok;
        logic [7:0] got;
        int f;
        p = f_a + FRAME - 1;
        wait_cyc(p - 1);
        checks++;
        if (bus.tx_full !== 1'b1 || bus.fifo_count !== 5'd16) begin
            errors++;
            $display("FAIL race_pre: full=%0b count=%0d, need 1/16", bus.tx_full, bus.fifo_count);
        end
        bus.tx_byte = 8'($urandom);
        bus.tx_wr   = 1'b1;
        @(negedge clk);
        bus.tx_wr   = 1'b0;
        checks++;
        if (bus.fifo_count !== 5'd15 || bus.tx_full !== 1'b0) begin
            errors++;
            $display("FAIL race_pop: count=%0d full=%0b, need 15/0", bus.fifo_count, bus.tx_full);
        end
        @(negedge clk);
        checks++;
        if (bus.fifo_count !== 5'd15) begin
            errors++; $display("FAIL race_hold: count=%0d, need 15", bus.fifo_count);
        end
        wait_rx(17, 17 * FRAME + 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL full_rx_timeout: got %0d bytes, need 17", rx_q.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                got = rx_q.pop_front();
                f   = fall_q.pop_front();
                checks++;
                if (got !== exp_q[i] || f != f_a + i * FRAME) begin
                    errors++;
                    $display("FAIL full_frame%0d: data %02h at %0d, need %02h at %0d",
                             i, got, f, exp_q[i], f_a + i * FRAME);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int n2;
        int f;
        int bad;
        bit ok;
        logic [7:0] got;
        write_byte(8'h0F, n);
        f = n + 2;
        wait_cyc(n + 3);
        write_byte(8'($urandom), n2);
        wait_cyc(f + 4 * DIVISOR + DIVISOR / 2);
        checks++;
        if (bus.fifo_count !== 5'd1 || bus.tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: count=%0d busy=%0b, need 1/1",
                     bus.fifo_count, bus.tx_busy);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if (bus.tx !== 1'b1 || bus.fifo_count !== 5'd0 || bus.tx_busy !== 1'b0
            || bus.tx_full !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: tx=%0b count=%0d busy=%0b full=%0b, need 1/0/0/0",
                     bus.tx, bus.fifo_count, bus.tx_busy, bus.tx_full);
        end
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        bad = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_abandon: low samples=%0d bytes=%0d, need 0/0", bad, rx_q.size());
        end
        rx_q.delete();
        fall_q.delete();
        write_byte(8'h81, n);
        wait_rx(1, FRAME + 20, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL midreset_rx_timeout: got %0d bytes, need 1", rx_q.size());
        end else begin
            got = rx_q.pop_front();
            f   = fall_q.pop_front();
            checks++;
            if (got !== 8'h81 || f != n + 2) begin
                errors++;
                $display("FAIL midreset_after: data %02h at %0d, need 81 at %0d", got, f, n + 2);
            end
        end
    endtask

    task automatic test_wrap();
        int sent;
        int guard;
        bit ok;
        logic [7:0] got;
        sent  = 0;
        guard = 0;
        while (sent < 40 && guard < 40 * FRAME + 1000) begin
            if (bus.tx_full === 1'b0) begin
                bus.tx_byte = 8'(sent);
                bus.tx_wr   = 1'b1;
                @(negedge clk);
                bus.tx_wr   = 1'b0;
                sent++;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        checks++;
        if (sent != 40) begin
            errors++; $display("FAIL wrap_push: pushed %0d, need 40", sent);
        end
        wait_rx(40, 41 * FRAME, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL wrap_rx_timeout: got %0d bytes, need 40", rx_q.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                got = rx_q.pop_front();
                void'(fall_q.pop_front());
                checks++;
                if (got !== 8'(i)) begin
                    errors++; $display("FAIL wrap_byte%0d: got %02h, need %02h", i, got, 8'(i));
                end
            end
        end
        repeat (FRAME) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || bus.tx_busy !== 1'b0 || bus.fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL wrap_drain: extra=%0d busy=%0b count=%0d, need 0/0/0",
                     rx_q.size(), bus.tx_busy, bus.fifo_count);
        end
    endtask

    initial begin
        bus.tx_wr   = 1'b0;
        bus.tx_byte = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_full_pop_race();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
